// File: rtl/lab2_proc_imm_decode_ctrl.sv
// lab2_proc_imm_decode_ctrl
// Decode-stage controller for the lab2 pipelined processor. Accepts fetched
// instructions on a val/rdy port, classifies the opcode into the immediate-type
// select for the immediate generator, and holds up to two decoded entries in
// an elastic queue. It also supports pipeline squash and counts illegal opcodes.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   in_val/in_rdy  fetch-side handshake; in_inst is the instruction word
//   out_val/out_rdy  X-side handshake for the head entry
//   out_inst       head instruction (to immediate generator inst input)
//   out_imm_type   head immediate-type select (to immediate generator)
//   out_imm_used   head instruction consumes an immediate
//   out_illegal    head opcode is unrecognised
//   squash         flush every buffered entry; overrides same-cycle transfers
//   illegal_cnt    saturating count of accepted illegal instructions
module lab2_proc_imm_decode_ctrl #(
   parameter int unsigned CNT_W = 16,
   parameter logic [2:0]  IMM_I = 3'd0,
   parameter logic [2:0]  IMM_S = 3'd1,
   parameter logic [2:0]  IMM_B = 3'd2,
   parameter logic [2:0]  IMM_U = 3'd3,
   parameter logic [2:0]  IMM_J = 3'd4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [31:0]      in_inst,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [31:0]      out_inst,
   output logic [2:0]       out_imm_type,
   output logic             out_imm_used,
   output logic             out_illegal,
   input  logic             squash,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int unsigned DEPTH = 2;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // One buffered, already-decoded instruction.
   typedef struct packed {
      logic [31:0] inst;
      logic [2:0]  imm_type;
      logic        imm_used;
      logic        illegal;
   } entry_t;

   entry_t             r_mem [DEPTH];
   logic               r_enq_ptr;
   logic               r_deq_ptr;
   logic [1:0]         r_count;
   logic [CNT_W-1:0]   r_illegal_cnt;

   entry_t             w_dec;
   logic               w_enq;
   logic               w_deq;
   entry_t             w_head;

   // Opcode classification, done once on the way into the queue.
   always_comb begin
      w_dec.inst     = in_inst;
      w_dec.imm_type = IMM_I;
      w_dec.imm_used = 1'b0;
      w_dec.illegal  = 1'b0;
      case (in_inst[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_dec.imm_used = 1'b1;
         OPC_STORE: begin
            w_dec.imm_type = IMM_S;
            w_dec.imm_used = 1'b1;
         end
         OPC_BRANCH: begin
            w_dec.imm_type = IMM_B;
            w_dec.imm_used = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            w_dec.imm_type = IMM_U;
            w_dec.imm_used = 1'b1;
         end
         OPC_JAL: begin
            w_dec.imm_type = IMM_J;
            w_dec.imm_used = 1'b1;
         end
         OPC_OP: w_dec.imm_used = 1'b0;
         default: w_dec.illegal = 1'b1;
      endcase
   end

   // Full blocks enqueue even when the head leaves this cycle (no pass-through).
   assign in_rdy  = !reset && (r_count != 2'd2);
   assign out_val = (r_count != 2'd0);

   // Squash cancels both sides of the handshake.
   assign w_enq = in_val && in_rdy && !squash;
   assign w_deq = out_val && out_rdy && !squash;

   assign w_head       = r_mem[r_deq_ptr];
   assign out_inst     = w_head.inst;
   assign out_imm_type = w_head.imm_type;
   assign out_imm_used = w_head.imm_used;
   assign out_illegal  = w_head.illegal;
   assign illegal_cnt  = r_illegal_cnt;

   // Queue storage, pointers, occupancy and illegal counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         // Storage cleared so the head reads zero straight out of reset.
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_enq_ptr     <= 1'b0;
         r_deq_ptr     <= 1'b0;
         r_count       <= 2'd0;
         r_illegal_cnt <= '0;
      end else if (squash) begin
         r_enq_ptr <= 1'b0;
         r_deq_ptr <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_enq) begin
            r_mem[r_enq_ptr] <= w_dec;
            r_enq_ptr        <= ~r_enq_ptr;
            if (w_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
               r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
         end
         if (w_deq) begin
            r_deq_ptr <= ~r_deq_ptr;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: doc/lab2_proc_imm_decode_ctrl.md
Name: lab2_proc_imm_decode_ctrl

Overview:
Decode-stage controller that sits between instruction fetch and the immediate generator / X stage of the lab2 pipelined processor. It accepts instructions over a val/rdy interface and classifies the opcode into the 3-bit immediate-type select that configures the immediate generator. It buffers up to two decoded instructions in an elastic queue, supports pipeline squash, and counts illegal opcodes.

Parameters:
CNT_W, 16, width of the saturating illegal-instruction counter
IMM_I, 3'd0, imm_type code for I-type
IMM_S, 3'd1, imm_type code for S-type
IMM_B, 3'd2, imm_type code for B-type
IMM_U, 3'd3, imm_type code for U-type
IMM_J, 3'd4, imm_type code for J-type

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_val  input  1  fetch presents a valid instruction
in_rdy  output  1  block can accept an instruction this cycle
in_inst  input  32  instruction word
out_val  output  1  head entry valid
out_rdy  input  1  downstream accepts head entry
out_inst  output  32  head instruction, fed to the immediate generator inst input
out_imm_type  output  3  head immediate-type select, fed to the immediate generator imm_type input
out_imm_used  output  1  head instruction consumes an immediate
out_illegal  output  1  head opcode is unrecognised
squash  input  1  flush all buffered entries
illegal_cnt  output  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Decode on enqueue, from inst[6:0]; result stored with the entry:
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR -> IMM_I, used=1.
  - 0100011 STORE -> IMM_S, used=1.
  - 1100011 BRANCH -> IMM_B, used=1.
  - 0110111 LUI, 0010111 AUIPC -> IMM_U, used=1.
  - 1101111 JAL -> IMM_J, used=1.
  - 0110011 OP -> IMM_I, used=0.
  - Anything else -> IMM_I, used=0, illegal=1.
- Queue structure:
  - 2-entry circular buffer, 1-bit enq/deq pointers, 2-bit count (0..2).
  - No bypass: an instruction accepted in cycle N is visible on out_* at the earliest in cycle N+1.
- Handshake signals:
  - in_rdy = !reset && count != 2. in_rdy is not asserted when full, even if a dequeue happens that cycle.
  - out_val = count != 0. out_* are driven from the head entry.
  - A transfer happens when val && rdy on the same edge.
  - out_inst, out_imm_type, out_imm_used and out_illegal must stay stable while out_val=1 and out_rdy=0.
- Simultaneous enq+deq:
  - At count=1: count stays 1, both pointers advance.
  - At count=2: only the dequeue can occur.
- Squash (priority over all transfers):
  - Next cycle count=0 and pointers=0.
  - The same-cycle enqueue is discarded and the same-cycle dequeue is ignored internally; downstream treats the squash itself as the discard.
  - illegal_cnt is not incremented for a discarded enqueue.
- Illegal counter:
  - Increments by 1 on each accepted enqueue with illegal=1.
  - Saturates at 2^CNT_W-1. It is not cleared by squash.
- Reset (synchronous, also mid-operation):
  - Next edge: count=0, pointers=0, illegal_cnt=0, out_val=0, out_inst=0, out_imm_type=0, out_imm_used=0, out_illegal=0.
  - in_rdy=0 while reset is high. Any in-flight transfer is dropped.
- Entry data storage has no reset requirement. out_* data are don't-care when out_val=0, except immediately after reset, where they read 0.
- Throughput: sustains 1 instruction/cycle with out_rdy held high.

Test Plan:
- Type mapping: enqueue, one at a time with out_rdy=1, 0x00500093 (addi), 0x00112223 (sw), 0x00208463 (beq), 0x123450B7 (lui), 0x008000EF (jal), 0x002081B3 (add). Required out_imm_type sequence 0,1,2,3,4,0; out_imm_used=1,1,1,1,1,0; out_illegal=0 throughout; each appears exactly one cycle after acceptance.
- Backpressure/full: out_rdy=0, present 3 instructions back-to-back. The first two are accepted, then in_rdy=0 with the third held. Raise out_rdy: the outputs are drained in order, and the third is accepted only after the count drops to 1.
- Streaming: out_rdy=1, in_val=1 for 10 cycles with instructions A0..A9. Required: 10 outputs in order, in_rdy stays 1, no bubbles after the first.
- Squash: fill 2 entries, then assert squash together with in_val=1 and an illegal word 0x0000007F. Next cycle out_val=0, count=0, and illegal_cnt is unchanged.
- Illegal counter: set CNT_W=2 and enqueue 5 instructions with opcode 0x7F. Required: out_illegal=1 on each, illegal_cnt goes 1,2,3,3,3.
- Reset mid-stream: with 2 entries queued and illegal_cnt=3, assert reset for 1 cycle. Required: out_val=0, in_rdy=0 during reset, illegal_cnt=0 after reset, and a following addi emerges normally.
